// File: rtl/rgd_pkg.sv
// rgd_pkg: shared types and defaults for the RGD requester front end.
`timescale 1ns/1ps
package rgd_pkg;
  typedef enum logic [1:0] {IDLE, REQ, OWN, REL} state_e;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int LEN_W_DEF = 8;
endpackage

// File: rtl/rgd_requester_if.sv
// rgd_requester_if: local command/status plus RGD wires of one requester port.
// Optional timeout signals exist only when RGD_REQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
import rgd_pkg::*;
interface rgd_requester_if #(parameter int LEN_W = LEN_W_DEF);
  logic start;
  logic [LEN_W-1:0] len;
  logic busy, own, done_pulse, r, d, g;
`ifdef RGD_REQ_TIMEOUT_EN
  logic [LEN_W-1:0] wait_max;
  logic timeout_err, timeout_clr;
  modport slave (input start, len, g, wait_max, timeout_clr, output busy, own, done_pulse, r, d, timeout_err);
  modport master (output start, len, g, wait_max, timeout_clr, input busy, own, done_pulse, r, d, timeout_err);
`else
  modport slave (input start, len, g, output busy, own, done_pulse, r, d);
  modport master (output start, len, g, input busy, own, done_pulse, r, d);
`endif
endinterface

// File: rtl/rgd_sync.sv
// rgd_sync: SYNC_STAGES-deep flop synchronizer, sync active-low reset to 0.
`timescale 1ns/1ps
module rgd_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] ff_q;
  always_ff @(posedge clk)
    ff_q <= !rstn ? '0 : {ff_q[SYNC_STAGES-2:0], d_i};
  assign q_o = ff_q[SYNC_STAGES-1];
endmodule

// File: rtl/rgd_requester.sv
// rgd_requester: turns a start pulse into a four-phase RGD request/own/release cycle.
// Optional sticky grant-wait timeout enabled by RGD_REQ_TIMEOUT_EN.
`timescale 1ns/1ps
module rgd_requester
  import rgd_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input logic clk,
  input logic rstn,
  rgd_requester_if.slave bus
);
  state_e state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic g_s, done_d, done_q, r_q, own_q, d_q;
  rgd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rstn(rstn), .d_i(bus.g), .q_o(g_s));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = REQ;
        cnt_d = (bus.len == '0) ? LEN_W'(1) : bus.len;
      end
      REQ: if (g_s) state_d = OWN;
      OWN: if (cnt_q == LEN_W'(1)) state_d = REL; else cnt_d = cnt_q - LEN_W'(1);
      REL: if (!g_s) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      r_q <= 1'b0;
      own_q <= 1'b0;
      d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      r_q <= state_d != IDLE;
      own_q <= state_d == OWN;
      d_q <= state_d == REL;
    end
  assign bus.r = r_q;
  assign bus.busy = r_q;
  assign bus.own = own_q;
  assign bus.d = d_q;
  assign bus.done_pulse = done_q;
`ifdef RGD_REQ_TIMEOUT_EN
  // wait counter saturates at wait_max so the error fires once per REQ visit
  logic [LEN_W-1:0] wcnt_q, wcnt_d;
  logic err_q, err_d, hit;
  always_comb begin
    wcnt_d = state_q != REQ ? '0 : (!g_s && wcnt_q != bus.wait_max) ? wcnt_q + LEN_W'(1) : wcnt_q;
    hit = state_q == REQ && !g_s && bus.wait_max != '0 && wcnt_q + LEN_W'(1) == bus.wait_max;
    err_d = hit | (err_q & ~bus.timeout_clr);
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      wcnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q <= err_d;
    end
  assign bus.timeout_err = err_q;
`endif
endmodule

// File: tb/tb_rgd_requester.sv
// tb_rgd_requester: directed + randomized bench for rgd_requester with a behavioural arbiter.
`timescale 1ns/1ps
module tb_rgd_requester;
  import rgd_pkg::*;
  localparam int S = 2;
  localparam int LW = 8;
  logic clk = 1'b0;
  logic rstn;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  rgd_requester_if #(.LEN_W(LW)) a();
  rgd_requester_if #(.LEN_W(LW)) b();
  rgd_requester #(.SYNC_STAGES(S), .LEN_W(LW)) dut_a (.clk(clk), .rstn(rstn), .bus(a.slave));
  rgd_requester #(.SYNC_STAGES(S), .LEN_W(LW)) dut_b (.clk(clk), .rstn(rstn), .bus(b.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on port a; grant after gd cycles of r, release g after rd cycles of d.
  task automatic txn(input int len, input int gd, input int rd, input bit spam);
    int exp_own, exp_n, n, own_n, dn, gw, dw, viol;
    bit done;
    exp_own = (len == 0) ? 1 : len;
    exp_n = 2 * S + 3 + exp_own + gd + rd;
    n = 0; own_n = 0; dn = 0; gw = 0; dw = 0; viol = 0; done = 0;
    a.len = LW'(len);
    a.start = 1'b1;
    tick();
    n = 1;
    if (!spam) a.start = 1'b0;
    a.len = LW'($urandom);
    chk("r_rise", a.r, 1);
    chk("busy_rise", a.busy, 1);
    while (!done && n < 200) begin
      if (a.r && !a.d && !a.g) begin
        if (gw == gd) a.g = 1'b1; else gw++;
      end
      if (a.d && a.g) begin
        if (dw == rd) a.g = 1'b0; else dw++;
      end
      tick();
      n++;
      own_n += int'(a.own);
      dn += int'(a.done_pulse);
      if (a.own && (!a.r || a.d)) viol++;
      if (a.busy !== a.r) viol++;
      if (a.done_pulse) begin
        done = 1;
        a.start = 1'b0;
      end
    end
    chk("txn_done", done, 1);
    chk("txn_latency", n, exp_n);
    chk("own_cycles", own_n, exp_own);
    chk("proto", viol, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      dn += int'(a.done_pulse);
      if (a.r || a.d || a.own || a.busy) viol++;
    end
    chk("done_once", dn, 1);
    chk("quiet_after", viol, 0);
  endtask

  // Two requesters against a round-robin arbiter model.
  task automatic arb_test(input int la, input int lb);
    int owner, last, da, db, oa, ob, mutex, n;
    owner = 0; last = 2; da = 0; db = 0; oa = 0; ob = 0; mutex = 0; n = 0;
    a.len = LW'(la);
    b.len = LW'(lb);
    a.start = 1'b1;
    b.start = 1'b1;
    tick();
    a.start = 1'b0;
    b.start = 1'b0;
    while ((da == 0 || db == 0) && n < 400) begin
      if (owner == 1 && a.d) begin a.g = 1'b0; owner = 0; last = 1; end
      if (owner == 2 && b.d) begin b.g = 1'b0; owner = 0; last = 2; end
      if (owner == 0) begin
        if (a.r && !a.d && (!(b.r && !b.d) || last == 2)) begin a.g = 1'b1; owner = 1; end
        else if (b.r && !b.d) begin b.g = 1'b1; owner = 2; end
      end
      tick();
      n++;
      if (a.own && b.own) mutex++;
      oa += int'(a.own);
      ob += int'(b.own);
      da += int'(a.done_pulse);
      db += int'(b.done_pulse);
    end
    chk("arb_mutex", mutex, 0);
    chk("arb_done_a", da, 1);
    chk("arb_done_b", db, 1);
    chk("arb_own_a", oa, (la == 0) ? 1 : la);
    chk("arb_own_b", ob, (lb == 0) ? 1 : lb);
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    a.start = 1'b0; a.len = '0; a.g = 1'b0;
    b.start = 1'b0; b.len = '0; b.g = 1'b0;
`ifdef RGD_REQ_TIMEOUT_EN
    a.wait_max = '0; a.timeout_clr = 1'b0;
    b.wait_max = '0; b.timeout_clr = 1'b0;
`endif
    a.start = 1'b1;
    tick();
    tick();
    chk("rst_r", a.r, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_own", a.own, 0);
    chk("rst_d", a.d, 0);
    chk("rst_done", a.done_pulse, 0);
`ifdef RGD_REQ_TIMEOUT_EN
    chk("rst_err", a.timeout_err, 0);
`endif
    a.start = 1'b0;
    rstn = 1'b1;
    tick();

    txn(4, 3, 2, 0);
    txn(0, 0, 0, 0);
    txn(1, 0, 0, 0);
    txn(5, 1, 1, 1);

    a.g = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n += int'(a.r) + int'(a.busy);
    end
    chk("idle_g_ignored", n, 0);
    a.g = 1'b0;
    repeat (S + 1) tick();

    for (int i = 0; i < 8; i++)
      txn(int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), (i % 3) == 0);

    a.len = 8'd20;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    a.g = 1'b1;
    n = 0;
    while (!a.own && n < 50) begin tick(); n++; end
    chk("reach_own", a.own, 1);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("midrst_r", a.r, 0);
    chk("midrst_d", a.d, 0);
    chk("midrst_own", a.own, 0);
    chk("midrst_busy", a.busy, 0);
    a.g = 1'b0;
    repeat (S + 1) tick();
    txn(3, 0, 0, 0);

    arb_test(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
    arb_test(6, 2);

`ifdef RGD_REQ_TIMEOUT_EN
    a.wait_max = 8'd10;
    a.len = 8'd2;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    repeat (9) tick();
    chk("to_not_yet", a.timeout_err, 0);
    tick();
    chk("to_set", a.timeout_err, 1);
    chk("to_r_held", a.r, 1);
    repeat (3) tick();
    chk("to_sticky", a.timeout_err, 1);
    a.timeout_clr = 1'b1;
    tick();
    a.timeout_clr = 1'b0;
    chk("to_clr", a.timeout_err, 0);
    a.g = 1'b1;
    n = 0;
    while (!a.done_pulse && n < 100) begin
      if (a.d) a.g = 1'b0;
      tick();
      n++;
    end
    chk("to_late_done", a.done_pulse, 1);
    chk("to_err_after", a.timeout_err, 0);
    a.wait_max = '0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
